mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own control FSM.
- Sits in EX beside the single-cycle ALU. The decode stage steers OP-type instructions with func7 = 0000001 here instead of to the ALU.
- Stalls the pipeline while an operation is in flight.
- Does one shift-add or restoring-subtract step per cycle over a shared 64-bit working register.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported. The iteration counter is $clog2(XLEN)+1 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  pipeline flush; aborts the current operation
- start  in  1  request a new operation; sampled on the clk edge
- func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  in  XLEN  rs1 value (multiplicand / dividend)
- operand_b  in  XLEN  rs2 value (multiplier / divisor)
- busy  out  1  high whenever state != IDLE
- done  out  1  single-cycle pulse; result valid in that cycle
- result  out  XLEN  final result; held until the next accepted start

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0. Reset asserted in any state returns to IDLE next edge with no done.
- States: IDLE, MUL, DIV, DONE.
- Start acceptance: start is accepted only in IDLE or DONE. Start is ignored in MUL/DIV; operands are not re-sampled.
- On accept, latch func3, operand magnitudes and sign-correction flags, and load counter=XLEN.
- Signedness:
  - operand_a is signed for MULH, MULHSU, DIV, REM.
  - operand_b is signed for MULH, DIV, REM.
  - Negative signed operands are converted to magnitude (two's complement) at accept.
- Multiply path, next state MUL:
  - Each cycle: if acc[0], add the multiplicand magnitude into acc[63:32] with carry out; then shift the 65-bit {carry, acc} right by 1.
  - Counter decrements; at counter==1 the next state is DONE.
  - Issue at t gives done at t+33.
- Divide path, next state DIV:
  - Restoring division: shift {rem, quot} left by 1; trial-subtract the divisor from rem; on no borrow keep the difference and set quot[0]=1.
  - 32 iterations; done at t+33.
- Special divide cases resolve at accept with next state DONE directly, so done is at t+1:
  - Divisor==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give operand_a.
  - Signed overflow (operand_a==0x80000000, operand_b==0xFFFFFFFF, DIV/REM): DIV gives 0x80000000; REM gives 0.
- Sign correction, applied on entry to DONE:
  - Product is negated if sign_a^sign_b.
  - Quotient is negated if sign_a^sign_b.
  - Remainder takes the sign of the dividend.
- Result selection: MUL gives the low 32 bits; MULH/MULHSU/MULHU give the high 32 bits; DIV* give the quotient; REM* give the remainder.
- DONE: result registered, done=1 for exactly one cycle.
  - Next state is IDLE, or MUL/DIV/DONE if start is accepted in the same cycle, giving back-to-back operation.
- Flush: in any state, the next state is IDLE.
  - done is never asserted for the flushed operation; result keeps its previous value.
  - Flush and start together: flush wins and start is dropped.
  - Flush in DONE cycle: done still pulses that cycle, since the result was already produced.
- Stall contract: the pipeline holds EX while busy && !done.

Decomposition:
- Package mdu_pkg holds:
  - func3 localparams: MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU.
  - mdu_state_t enum: IDLE, MUL, DIV, DONE.
  - Helper functions is_div(func3) and a_signed/b_signed(func3).
- Sub-module mdu_operand_prep (combinational): func3 + operands → magnitudes, neg_result, neg_rem, div_by_zero, div_overflow.
- FSM, counter and working register stay in the top module.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, start at t → busy=1 over t+1..t+33; done only at t+33; result=0xFFFFFFEB.
- a=b=0xFFFFFFFF → MULHU=0xFFFFFFFE, MULH=0x00000000, MULHSU=0xFFFFFFFF, MUL=0x00000001; each with done at t+33.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Special cases, each with done at t+1:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Flush and reset:
  - Flush at t+10 of a MUL → busy=0 at t+11, no done pulse, result unchanged; a new DIVU 9/3 at t+11 gives 3 at t+44.
  - rst at t+5 of a DIV behaves the same, with result=0.
- Start asserted during MUL with different operands → ignored, original result returned at t+33.
  - Start asserted in the DONE cycle (t+33) → accepted; second result done at t+66 with no idle gap.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types, widths and func3 decode helpers for the RV32M multiply/divide unit.
package mdu_pkg;

  // Only XLEN = 32 is supported.
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] f);
    return (f == MDU_MULH) || (f == MDU_MULHSU) || (f == MDU_DIV) || (f == MDU_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f);
    return (f == MDU_MULH) || (f == MDU_DIV) || (f == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
  import mdu_pkg::*;

  logic            flush;
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output flush, start, func3, operand_a, operand_b,
    input  busy, done, result
  );

  modport slave (
    input  flush, start, func3, operand_a, operand_b,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_operand_prep.sv
// Converts raw operands to magnitudes and derives sign-fix and special-case flags.
module mdu_operand_prep
  import mdu_pkg::*;
(
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_result,
  output logic            neg_rem,
  output logic            div_by_zero,
  output logic            div_overflow
);

  logic sign_a;
  logic sign_b;

  // Sign extraction, magnitude conversion and divide special-case detection.
  always_comb begin
    sign_a       = a_signed(func3) && operand_a[XLEN-1];
    sign_b       = b_signed(func3) && operand_b[XLEN-1];
    mag_a        = sign_a ? (~operand_a + XLEN'(1)) : operand_a;
    mag_b        = sign_b ? (~operand_b + XLEN'(1)) : operand_b;
    neg_result   = sign_a ^ sign_b;
    neg_rem      = sign_a;
    div_by_zero  = is_div(func3) && (operand_b == '0);
    div_overflow = is_div(func3) && !func3[0]
                   && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (operand_b == '1);
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per cycle.
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  mdu_state_t        state_q, state_d, start_tgt_c;
  logic [2:0]        func3_q;
  logic [XLEN-1:0]   mag_a_q, mag_b_q;
  logic              neg_result_q, neg_rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  logic [XLEN-1:0]   mag_a, mag_b;
  logic              neg_result, neg_rem, div_by_zero, div_overflow;

  logic              accept_c, busy_d, done_d, wr_result_c;
  logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   quot, rem, final_res, special_res, res_d;

  mdu_operand_prep u_prep (
    .func3        (bus.func3),
    .operand_a    (bus.operand_a),
    .operand_b    (bus.operand_b),
    .mag_a        (mag_a),
    .mag_b        (mag_b),
    .neg_result   (neg_result),
    .neg_rem      (neg_rem),
    .div_by_zero  (div_by_zero),
    .div_overflow (div_overflow)
  );

  // One multiply step and one restoring-divide step computed from the working register.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]};
    if (acc_q[0]) mul_sum = mul_sum + {1'b0, mag_a_q};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, mag_b_q};
    if (!rem_diff[XLEN]) div_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                 div_next = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Sign correction and result selection after the last step, plus special-case results.
  always_comb begin
    prod = neg_result_q ? (~mul_next + (2*XLEN)'(1)) : mul_next;
    quot = div_next[XLEN-1:0];
    rem  = div_next[2*XLEN-1:XLEN];
    if (is_div(func3_q)) begin
      if (func3_q[1]) final_res = neg_rem_q ? (~rem + XLEN'(1)) : rem;
      else            final_res = neg_result_q ? (~quot + XLEN'(1)) : quot;
    end else begin
      final_res = (func3_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
    if (div_by_zero) special_res = bus.func3[1] ? bus.operand_a : '1;
    else             special_res = bus.func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides everything, including a same-cycle start.
  always_comb begin
    state_d  = state_q;
    accept_c = bus.start && !bus.flush && ((state_q == IDLE) || (state_q == DONE));
    if (!is_div(bus.func3))              start_tgt_c = MUL;
    else if (div_by_zero || div_overflow) start_tgt_c = DONE;
    else                                 start_tgt_c = DIV;
    case (state_q)
      IDLE:     if (accept_c) state_d = start_tgt_c;
      MUL, DIV: if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:     state_d = accept_c ? start_tgt_c : IDLE;
      default:  state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // Output decode: registered status follows the next state; result written on entry to DONE.
  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    wr_result_c = (state_d == DONE);
    res_d       = accept_c ? special_res : final_res;
  end

  // Operand latch, iteration counter, working register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      func3_q      <= MDU_MUL;
      mag_a_q      <= '0;
      mag_b_q      <= '0;
      neg_result_q <= 1'b0;
      neg_rem_q    <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (wr_result_c) result_q <= res_d;
      if (accept_c) begin
        func3_q      <= bus.func3;
        mag_a_q      <= mag_a;
        mag_b_q      <= mag_b;
        neg_result_q <= neg_result;
        neg_rem_q    <= neg_rem;
        cnt_q        <= CNT_W'(XLEN);
        acc_q        <= is_div(bus.func3) ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      end else if (state_q == MUL) begin
        acc_q <= mul_next;
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (state_q == DIV) begin
        acc_q <= div_next;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for the multiply/divide sequencer.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mdu_if bus ();

  mdu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request so it is sampled on the next rising edge; returns 1ns after that edge.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.func3     = f;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count cycles from the issue edge until done (cycle t+1 is 1); bounded by max.
  task automatic wait_done(input int max, output int lat, output bit busy_ok);
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < max) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.busy) busy_ok = 1'b0;
  endtask

  // Full operation: latency, result, busy throughout, and a single-cycle done pulse.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int lat;
    bit bok;
    launch(f, a, b);
    wait_done(80, lat, bok);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, bus.result, exp_res);
    chk({tag, "_busy"}, 32'(bok), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    bit bok;
    int done_seen;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.start     = 1'b0;
    bus.func3     = MDU_MUL;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst = 1'b0;

    // Multiply variants
    run_op("mul_7xm3", MDU_MUL, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB);
    run_op("mulhu_ff", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
    run_op("mulh_ff", MDU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0000);
    run_op("mulhsu_ff", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF);
    run_op("mul_ff", MDU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001);

    // Divide variants
    run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    run_op("rem_m7_2", MDU_REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 33, 32'd14);
    run_op("remu_100_7", MDU_REMU, 32'd100, 32'd7, 33, 32'd2);

    // Special cases resolved at accept
    run_op("div_by0", MDU_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("remu_by0", MDU_REMU, 32'd5, 32'd0, 1, 32'd5);
    run_op("rem_m5_by0", MDU_REM, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem_ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);

    // Flush mid-multiply: no done, result held, then a fresh divide
    run_op("mul_3x5", MDU_MUL, 32'd3, 32'd5, 33, 32'd15);
    launch(MDU_MUL, 32'h1234, 32'd2);
    done_seen = 0;
    repeat (9) begin
      if (bus.done) done_seen++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_nodone_pre", 32'(done_seen), 32'd0);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_done", 32'(bus.done), 32'd0);
    chk("flush_result", bus.result, 32'd15);
    run_op("divu_9_3", MDU_DIVU, 32'd9, 32'd3, 33, 32'd3);

    // Flush together with start in IDLE drops the start
    @(negedge clk);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.func3 = MDU_MUL;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    chk("flush_start_busy", 32'(bus.busy), 32'd0);
    chk("flush_start_res", bus.result, 32'd3);

    // Reset mid-divide clears the result and produces no done
    launch(MDU_DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_done", 32'(bus.done), 32'd0);
    chk("rstmid_result", bus.result, 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    chk("rstmid_nodone", 32'(done_seen), 32'd0);

    // Start during MUL is ignored; start in the DONE cycle is accepted back-to-back
    launch(MDU_MUL, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.func3     = MDU_DIVU;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(80, lat, bok);
    chk("ign_lat", 32'(lat + 5), 32'd33);
    chk("ign_res", bus.result, 32'd42);
    launch(MDU_MUL, 32'd9, 32'd9);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_done_low", 32'(bus.done), 32'd0);
    chk("b2b_hold", bus.result, 32'd42);
    wait_done(80, lat, bok);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_res", bus.result, 32'd81);
    chk("b2b_busyok", 32'(bok), 32'd1);

    // Flush plus start in the DONE cycle: pulse already out, nothing new starts
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.start     = 1'b1;
    bus.func3     = MDU_DIVU;
    bus.operand_a = 32'd8;
    bus.operand_b = 32'd2;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    chk("flush_done_busy", 32'(bus.busy), 32'd0);
    chk("flush_done_done", 32'(bus.done), 32'd0);
    chk("flush_done_res", bus.result, 32'd81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
